// File: rtl/data_mem_responder_if.sv
// Request/response bus between the datapath's data-memory port and the
// data_mem_responder. The requester drives the request side and takes
// responses. The responder answers each request after its wait states.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           rdata;
    logic                  err;

    modport master (
        output req_valid, MemRead, MemWrite, addr, wdata, resp_ready,
        input  req_ready, resp_valid, rdata, err
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, addr, wdata, resp_ready,
        output req_ready, resp_valid, rdata, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a valid/ready handshake.
// It accepts one load or store in IDLE and spends WAIT_CYCLES cycles in WAIT.
// It performs the access on the edge that enters RESP, then holds the response
// until the requester takes it. Malformed, misaligned and out-of-range requests
// return err=1 and rdata=0, and they do not touch the array.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus
);
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam bit DIRECT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;

    // Request fields captured at acceptance. Bus inputs are ignored after that.
    logic                  r_op_read;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    logic [31:0]           r_rdata;
    logic                  r_err;

    // Storage is deliberately left out of reset so contents survive rst_n.
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_sel_read;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [ADDR_WIDTH-3:0] w_index;
    logic [IW-1:0]         w_mem_idx;
    logic                  w_err;
    logic                  w_do_read;
    logic                  w_do_write;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // With no wait states, the access happens on the acceptance edge itself.
    // In that case the live bus fields are used instead of the latched copy.
    assign w_commit    = (DIRECT && w_accept) || ((r_state == ST_WAIT) && (r_cnt == '0));
    assign w_sel_read  = (r_state == ST_IDLE) ? bus.MemRead  : r_op_read;
    assign w_sel_write = (r_state == ST_IDLE) ? bus.MemWrite : r_op_write;
    assign w_sel_addr  = (r_state == ST_IDLE) ? bus.addr     : r_addr;
    assign w_sel_wdata = (r_state == ST_IDLE) ? bus.wdata    : r_wdata;

    assign w_index   = w_sel_addr[ADDR_WIDTH-1:2];
    assign w_mem_idx = IW'(w_index);
    assign w_err     = (w_sel_read == w_sel_write)
                     || (w_sel_addr[1:0] != 2'b00)
                     || (32'(w_index) >= 32'(DEPTH));

    assign w_do_read  = w_commit && w_sel_read && !w_err;
    // Gating with rst_n keeps a held request from writing while reset is asserted.
    assign w_do_write = w_commit && w_sel_write && !w_err && rst_n;

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.rdata      = r_rdata;
    assign bus.err        = r_err;

    // Next-state and wait-counter logic for IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (DIRECT) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, latched request and response registers. Reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_read  <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op_read  <= bus.MemRead;
                r_op_write <= bus.MemWrite;
                r_addr     <= bus.addr;
                r_wdata    <= bus.wdata;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= w_do_read ? r_mem[w_mem_idx] : 32'd0;
            end else if ((r_state == ST_RESP) && bus.resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    // Single write port. Only legal stores update the array, on their commit edge.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_mem_idx] <= w_sel_wdata;
        end
    end
endmodule
